// File: rtl/reg_writeback_8088.sv
// reg_writeback_8088: 4-entry writeback FIFO feeding an 8088 register bank; REG_WRITEBACK_DUAL_EN adds the DX second write.
module reg_writeback_8088 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_w,
  input  logic [2:0]  in_reg,
  input  logic [15:0] in_data,
  input  logic        in_dual,
  input  logic [15:0] in_data2,
  output logic        en_write,
  output logic [2:0]  reg_write,
  output logic [15:0] write_data,
  output logic        size,
  output logic        select_high_low,
  output logic        busy,
  output logic [15:0] wb_count
);
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;
  state_t      state;
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic        rdy;
  logic        f_w [4];
  logic [2:0]  f_reg [4];
  logic [15:0] f_data [4];
  logic        push, pop, wide;
  logic [2:0]  hreg, idx;
`ifdef REG_WRITEBACK_DUAL_EN
  logic        f_dual [4];
  logic [15:0] f_data2 [4];
  logic        cur_dual;
  logic [15:0] cur_data2;
  assign pop = cnt != 3'd0 && !(state == WR1 && cur_dual);
`else
  logic unused_dual;
  assign unused_dual = in_dual ^ (^in_data2);
  assign pop = cnt != 3'd0;
`endif
  assign in_ready = rdy && cnt != 3'd4;
  assign push = in_valid && in_ready;
  assign busy = cnt != 3'd0 || state != IDLE;
  assign wide = f_w[rp];
  assign hreg = f_reg[rp];
  // reg codes 0..3 are A,C,D,B; the bank orders them A,B,C,D
  assign idx = (wide && hreg[2]) ? hreg : {1'b0, hreg[0] ^ hreg[1], hreg[1]};
  always_ff @(posedge clk) begin
    if (push) begin
      f_w[wp] <= in_w;
      f_reg[wp] <= in_reg;
      f_data[wp] <= in_data;
`ifdef REG_WRITEBACK_DUAL_EN
      f_dual[wp] <= in_dual;
      f_data2[wp] <= in_data2;
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wp <= 2'd0;
      rp <= 2'd0;
      cnt <= 3'd0;
      rdy <= 1'b0;
      en_write <= 1'b0;
      reg_write <= 3'd0;
      write_data <= 16'd0;
      size <= 1'b0;
      select_high_low <= 1'b0;
      wb_count <= 16'd0;
`ifdef REG_WRITEBACK_DUAL_EN
      cur_dual <= 1'b0;
      cur_data2 <= 16'd0;
`endif
    end else begin
      rdy <= 1'b1;
      wb_count <= wb_count + {15'd0, en_write};
      wp <= wp + 2'(push);
      rp <= rp + 2'(pop);
      cnt <= cnt + 3'(push) - 3'(pop);
`ifdef REG_WRITEBACK_DUAL_EN
      if (state == WR1 && cur_dual) begin
        state <= WR2;
        en_write <= 1'b1;
        reg_write <= 3'd3;
        write_data <= cur_data2;
        size <= 1'b1;
        select_high_low <= 1'b0;
        cur_dual <= 1'b0;
      end else
`endif
      if (pop) begin
        state <= WR1;
        en_write <= 1'b1;
        reg_write <= idx;
        write_data <= wide ? f_data[rp] : {8'h00, f_data[rp][7:0]};
        size <= wide;
        select_high_low <= !wide && hreg[2];
`ifdef REG_WRITEBACK_DUAL_EN
        cur_dual <= f_dual[rp];
        cur_data2 <= f_data2[rp];
`endif
      end else begin
        state <= IDLE;
        en_write <= 1'b0;
        reg_write <= 3'd0;
        write_data <= 16'd0;
        size <= 1'b0;
        select_high_low <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_8088.sv
// tb_reg_writeback_8088: queue-based model of the writeback stream plus directed literal checks.
module tb_reg_writeback_8088;
`ifdef REG_WRITEBACK_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic clk = 0, reset = 1, in_valid = 0, in_w = 0, in_dual = 0;
  logic [2:0] in_reg = 0;
  logic [15:0] in_data = 0, in_data2 = 0;
  logic in_ready, en_write, size, select_high_low, busy;
  logic [2:0] reg_write;
  logic [15:0] write_data, wb_count;
  int vectors = 0, miscompares = 0;
  bit saw_full = 0;

  reg_writeback_8088 dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_w(in_w), .in_reg(in_reg), .in_data(in_data), .in_dual(in_dual), .in_data2(in_data2),
    .en_write(en_write), .reg_write(reg_write), .write_data(write_data), .size(size),
    .select_high_low(select_high_low), .busy(busy), .wb_count(wb_count));

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] r; logic [15:0] d; logic sz; logic hl;} wr_t;
  typedef struct packed {wr_t a; logic du; logic [15:0] d2;} ent_t;
  int wt[8] = '{0, 2, 3, 1, 4, 5, 6, 7};
  ent_t q[$];
  wr_t cur = '0;
  bit cen = 0, p2 = 0, rdy = 0;
  logic [15:0] p2d = 0, cnt = 0;

  function automatic wr_t mk(logic w, logic [2:0] r, logic [15:0] d);
    wr_t x;
    if (w) x = '{r: 3'(wt[r]), d: d, sz: 1'b1, hl: 1'b0};
    else x = '{r: 3'(wt[{1'b0, r[1:0]}]), d: {8'h00, d[7:0]}, sz: 1'b0, hl: r[2]};
    return x;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete(); cur = '0; cen = 0; p2 = 0; rdy = 0; cnt = 0;
    end else begin
      bit push;
      ent_t e, h;
      push = in_valid && rdy && q.size() < 4;
      e = '{a: mk(in_w, in_reg, in_data), du: DUAL && in_dual, d2: in_data2};
      cnt = cnt + 16'(cen);
      if (p2) begin cur = '{r: 3'd3, d: p2d, sz: 1'b1, hl: 1'b0}; cen = 1; p2 = 0; end
      else if (q.size() != 0) begin h = q.pop_front(); cur = h.a; cen = 1; p2 = h.du; p2d = h.d2; end
      else begin cur = '0; cen = 0; end
      if (push) q.push_back(e);
      rdy = 1;
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("en_write", 32'(en_write), 32'(cen));
    chk("reg_write", 32'(reg_write), 32'(cur.r));
    chk("write_data", 32'(write_data), 32'(cur.d));
    chk("size", 32'(size), 32'(cur.sz));
    chk("select_high_low", 32'(select_high_low), 32'(cur.hl));
    chk("busy", 32'(busy), 32'(cen || q.size() != 0));
    chk("wb_count", 32'(wb_count), 32'(cnt));
    chk("in_ready", 32'(in_ready), 32'(rdy && q.size() < 4));
  end

  task automatic send(logic w, logic [2:0] r, logic [15:0] d, logic du, logic [15:0] d2);
    int t = 0;
    @(negedge clk);
    in_valid = 1; in_w = w; in_reg = r; in_data = d; in_dual = du; in_data2 = d2;
    while (!in_ready && t < 50) begin saw_full = 1; @(negedge clk); t++; end
    if (t >= 50) chk("accept_timeout", 32'(t), 32'd0);
  endtask

  task automatic stop();
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    chk("ready_in_reset_release", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(in_ready), 32'd1);
    send(1, 3'd3, 16'h1234, 0, 0); stop();
    @(negedge clk);
    chk("bx_en", 32'(en_write), 32'd1);
    chk("bx_reg", 32'(reg_write), 32'd1);
    chk("bx_size", 32'(size), 32'd1);
    chk("bx_data", 32'(write_data), 32'h1234);
    @(negedge clk);
    chk("bx_count", 32'(wb_count), 32'd1);
    chk("bx_single", 32'(en_write), 32'd0);
    send(0, 3'd5, 16'hBEEF, 0, 0); stop();
    @(negedge clk);
    chk("ch_reg", 32'(reg_write), 32'd2);
    chk("ch_size", 32'(size), 32'd0);
    chk("ch_hl", 32'(select_high_low), 32'd1);
    chk("ch_data", 32'(write_data), 32'h00EF);
    send(1, 3'd0, 16'h0010, 1, 16'h0020); stop();
    @(negedge clk);
    chk("ax_reg", 32'(reg_write), 32'd0);
    chk("ax_data", 32'(write_data), 32'h0010);
    @(negedge clk);
`ifdef REG_WRITEBACK_DUAL_EN
    chk("dx_en", 32'(en_write), 32'd1);
    chk("dx_reg", 32'(reg_write), 32'd3);
    chk("dx_data", 32'(write_data), 32'h0020);
    @(negedge clk);
    chk("dual_count", 32'(wb_count), 32'd4);
`else
    chk("no_dx_en", 32'(en_write), 32'd0);
    chk("dual_count", 32'(wb_count), 32'd3);
`endif
    for (int i = 0; i < 16; i++) send(i[3], i[2:0], 16'hA500 + 16'(i * 17), 0, 0);
    stop();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) send(1, 3'(i), 16'h1000 + 16'(i), 1, 16'h2000 + 16'(i));
    stop();
    repeat (12) @(negedge clk);
`ifdef REG_WRITEBACK_DUAL_EN
    chk("saw_full", 32'(saw_full), 32'd1);
`endif
    send(1, 3'd1, 16'h5555, 1, 16'h6666); stop();
    @(negedge clk);
    @(negedge clk);
`ifdef REG_WRITEBACK_DUAL_EN
    chk("wr2_before_reset", 32'(reg_write), 32'd3);
`endif
    #2 reset = 1;
    #1;
    chk("rst_en", 32'(en_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(wb_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("no_dx_after_reset", 32'(en_write), 32'd0);
    send(0, 3'd0, 16'h77AB, 0, 0); stop();
    @(negedge clk);
    chk("al_data", 32'(write_data), 32'h00AB);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
